serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Sequences one structural full-adder cell (`Full_Adder_Structural`, ports a, b, c, sum, carry) to add two WIDTH-bit operands bit-serially, LSB first.
- Carry is held in a flip-flop between bits.
- Start/busy/done handshake; the result is registered and held until the next accepted start.
- Replaces a WIDTH-bit ripple adder in area-constrained lab datapaths at a cost of WIDTH+2 cycles per operation.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  operand A, captured on accepted start
- b_in  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse, result valid
- sum_out  output  WIDTH  registered sum
- cout  output  1  registered carry-out

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n): sampled only on the rising clk edge.
- State in reset: state=IDLE, busy=0, done=0, sum_out=0, cout=0. Operand shift registers, partial-sum register, carry flop and bit counter all cleared.
- States: IDLE, RUN, DONE. Encoding is free. busy = (state==RUN); done = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.
- IDLE -> RUN, on an edge with start=1:
  - latch a_in and b_in into shift registers;
  - carry flop <= cin;
  - bit counter <= 0.
- IDLE with start=0: hold.
- RUN, each edge:
  - the full adder sees a=A_sh[0], b=B_sh[0], c=carry flop;
  - A_sh and B_sh shift right by 1;
  - the sum bit shifts into the MSB of the partial-sum register (which shifts right);
  - carry flop <= full-adder carry;
  - counter increments.
- RUN -> DONE, on the edge that processes bit WIDTH-1 (counter==WIDTH-1):
  - sum_out <= final partial sum, with bit i = sum of operand bit i;
  - cout <= full-adder carry of that bit.
  - sum_out and cout change only on this edge or on reset.
- DONE -> IDLE unconditionally on the next edge.
- Timing, with start accepted at edge E:
  - busy high for exactly WIDTH cycles (edges E..E+WIDTH-1 into RUN);
  - done high during the single cycle after edge E+WIDTH;
  - earliest next acceptance is edge E+WIDTH+2. Throughput is one add per WIDTH+2 cycles.
- start in RUN or DONE: ignored, with no effect on the operation in progress and not queued.
- start held continuously high: re-accepted at every IDLE edge, with operands resampled at that edge.
- a_in, b_in, cin changes after acceptance: no effect on the result.
- Reset mid-operation (rst_n=0 at any edge): abort immediately to the reset state; sum_out and cout return to 0; no done pulse.
- Reset and start on the same edge: reset wins.
- Arithmetic: {cout, sum_out} = a_in + b_in + cin, exact modulo 2^(WIDTH+1).
- Counter width: $clog2(WIDTH)+1 bits. The counter must not wrap before the terminal compare.

Test Plan:
1. WIDTH=8, a_in=0x5A, b_in=0x3C, cin=0, one-cycle start -> busy high 8 cycles; done pulse 8 edges after acceptance; sum_out=0x96, cout=0.
2. a_in=0xFF, b_in=0x01, cin=0 -> sum_out=0x00, cout=1. Then a_in=0xFF, b_in=0xFF, cin=1 -> sum_out=0xFF, cout=1 (full carry propagation).
3. Start accepted with 0x10+0x20; pulse start again with 0xAA+0x55 on cycle 3 of RUN and during the DONE cycle -> single done, sum_out=0x30, cout=0. Second request is not performed; bench confirms no further done without a new IDLE start.
4. start tied high, operands changed between operations (0x01+0x01, then 0x80+0x80) -> done pulses exactly 10 cycles apart; results 0x02/cout=0, then 0x00/cout=1. sum_out holds each value between pulses.
5. rst_n driven 0 for one edge on RUN cycle 4 of a 0x7F+0x01 add -> next cycle state IDLE, busy=0, done=0, sum_out=0x00, cout=0. A new start for 0x03+0x04 yields 0x07.
6. WIDTH=4, exhaustive over all a, b, cin (512 ops), compared against a behavioural +. All match; done spacing is 6 cycles with start held high.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder reusing one structural full-adder cell,
// LSB first, with start/busy/done handshake and a registered result.

module Full_Adder_Structural (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    logic ab_x, ab_a, xc_a;
    xor g0 (ab_x, a, b);
    xor g1 (sum, ab_x, c);
    and g2 (ab_a, a, b);
    and g3 (xc_a, ab_x, c);
    or  g4 (carry, ab_a, xc_a);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [WIDTH-2:0] ps_q, ps_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] ps_next;

    Full_Adder_Structural u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .c    (carry_q),
        .sum  (fa_s),
        .carry(fa_c)
    );

    // Partial sum keeps only WIDTH-1 bits; the last sum bit goes straight into sum_out.
    assign ps_next = {fa_s, ps_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ps_d    = ps_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = a_in;
                b_d     = b_in;
                carry_d = cin;
                cnt_d   = '0;
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                ps_d    = ps_next[WIDTH-1:1];
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = ps_next;
                    cout_d  = fa_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ps_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ps_q    <= ps_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign sum_out = sum_q;
    assign cout    = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of the 8-bit serial adder plus an exhaustive
// 4-bit sweep with start held high.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, cin = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       busy8, done8, cout8;
    logic       start4 = 1'b0, c4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       busy4, done4, cout4;
    int         n_cmp = 0, n_err = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_adder_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a8), .b_in(b8), .cin(cin),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .cin(c4),
        .busy(busy4), .done(done4), .sum_out(sum4), .cout(cout4)
    );

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic ec);
        int k, bc;
        a8 = a; b8 = b; cin = ci; start = 1'b1;
        tick();
        start = 1'b0;
        k = 0; bc = 0;
        while (!done8 && k < 30) begin
            if (busy8) bc++;
            tick();
            k++;
        end
        chk("latency", k, 8);
        chk("busy_cycles", bc, 8);
        chk("sum", sum8, es);
        chk("cout", cout8, ec);
        tick();
        chk("done_clear", done8, 0);
    endtask

    initial begin
        int k, nd, chg, t0, t1;
        logic [4:0] exp5;
        tick(); tick();
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        rst_n = 1'b1;
        tick();

        add8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // start pulses during RUN and DONE must be ignored
        a8 = 8'h10; b8 = 8'h20; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a8 = 8'hAA; b8 = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!done8 && k < 30) begin tick(); k++; end
        chk("ign_latency", k + 3, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_sum", sum8, 8'h30);
        chk("ign_cout", cout8, 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) nd++;
        end
        chk("ign_no_rerun", nd, 0);
        chk("ign_sum_hold", sum8, 8'h30);

        // start held high, operands changed right after acceptance
        a8 = 8'h01; b8 = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        a8 = 8'h80; b8 = 8'h80;
        k = 0;
        while (!done8 && k < 30) begin tick(); k++; end
        t0 = cyc;
        chk("hold1_sum", sum8, 8'h02);
        chk("hold1_cout", cout8, 0);
        k = 0; chg = 0;
        do begin
            tick(); k++;
            if (!done8 && (sum8 !== 8'h02 || cout8 !== 1'b0)) chg++;
        end while (!done8 && k < 30);
        t1 = cyc;
        start = 1'b0;
        chk("hold_between", chg, 0);
        chk("hold_spacing", t1 - t0, 10);
        chk("hold2_sum", sum8, 8'h00);
        chk("hold2_cout", cout8, 1);
        tick();

        // reset on RUN cycle 4 aborts the add
        a8 = 8'h7F; b8 = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_busy", busy8, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_sum", sum8, 0);
        chk("abort_cout", cout8, 0);
        add8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

        // reset and start on the same edge: reset wins
        a8 = 8'h11; b8 = 8'h22; start = 1'b1; rst_n = 1'b0;
        tick();
        start = 1'b0; rst_n = 1'b1;
        chk("rst_vs_start", busy8, 0);
        tick();

        // exhaustive 4-bit sweep, start held high
        t0 = 0;
        for (int i = 0; i < 512; i++) begin
            {a4, b4, c4} = 9'(i);
            start4 = 1'b1;
            exp5 = 5'(a4) + 5'(b4) + 5'(c4);
            k = 0;
            do begin tick(); k++; end while (!done4 && k < 20);
            chk("w4_result", {cout4, sum4}, exp5);
            if (i > 0) chk("w4_spacing", cyc - t0, 6);
            t0 = cyc;
        end
        start4 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
